msgdma_desc_submit: RTL and testbench

MSGDMA_DESC_SUBMIT -- requirements
Module: msgdma_desc_submit

---
 rtl/msgdma_desc_pkg.sv | 39 +++
 rtl/poll_gap_counter.sv | 42 ++++
 rtl/msgdma_desc_submit.sv | 173 +++++++++++++++++
 tb/tb_msgdma_desc_submit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msgdma_desc_pkg.sv
// Shared types and constants for the mSGDMA descriptor submitter.
package msgdma_desc_pkg;

  localparam int unsigned ADDR_W = 48;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned CSR_AW = 8;
  localparam int unsigned CSR_DW = 64;
  localparam int unsigned STAT_W = 32;
  localparam int unsigned GAP_W  = 16;

  localparam int unsigned OFF_SRC = 0;
  localparam int unsigned OFF_DST = 1;
  localparam int unsigned OFF_LEN = 2;
  localparam int unsigned OFF_CTL = 3;

  localparam int unsigned GO_BIT   = 31;
  localparam int unsigned BUSY_BIT = 0;

  localparam logic [CSR_DW-1:0] CTL_WORD = CSR_DW'(1) << GO_BIT;

  typedef enum logic [3:0] {
    IDLE,
    WR_SRC,
    WR_DST,
    WR_LEN,
    WR_CTL,
    GAP,
    RD,
    RSP,
    DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } desc_req_t;

endpackage

// File: rtl/poll_gap_counter.sv
// Down-counter timing the idle interval between status polls; expire_o is a
// registered pulse during the last counted cycle.
module poll_gap_counter
  import msgdma_desc_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load_i) begin
      cnt_d    = GAP_W'(LOAD_VAL - 1);
      expire_d = (LOAD_VAL == 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d    = cnt_q - GAP_W'(1);
      expire_d = (cnt_q == GAP_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/msgdma_desc_submit.sv
// Submits one transfer as a 4-word mSGDMA descriptor over Avalon-MM CSR writes,
// then polls the status register until not busy and reports the final status.
module msgdma_desc_submit
  import msgdma_desc_pkg::*;
#(
  parameter logic [7:0]  DESC_BASE   = 8'h20,
  parameter logic [7:0]  STATUS_ADDR = 8'h00,
  parameter int unsigned POLL_GAP    = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [47:0] req_src,
  input  logic [47:0] req_dst,
  input  logic [31:0] req_len,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [31:0] done_status,
  output logic [7:0]  csr_address,
  output logic [63:0] csr_writedata,
  output logic [7:0]  csr_byteenable,
  output logic        csr_write,
  output logic        csr_read,
  output logic        csr_burstcount,
  input  logic [63:0] csr_readdata,
  input  logic        csr_readdatavalid,
  input  logic        csr_waitrequest
);

  state_e              state_q, state_d;
  desc_req_t           req_q, req_d;
  logic                req_ready_q, req_ready_d;
  logic                done_valid_q, done_valid_d;
  logic [STAT_W-1:0]   done_status_q, done_status_d;
  logic [CSR_AW-1:0]   csr_address_q, csr_address_d;
  logic [CSR_DW-1:0]   csr_writedata_q, csr_writedata_d;
  logic                csr_write_q, csr_write_d;
  logic                csr_read_q, csr_read_d;
  logic                gap_load_c;
  logic                gap_expire;
  logic                wr_ack_c;
  logic                unused_rdata_c;

  assign wr_ack_c       = csr_write_q && !csr_waitrequest;
  assign unused_rdata_c = ^csr_readdata[CSR_DW-1:STAT_W];

  poll_gap_counter #(
    .LOAD_VAL (POLL_GAP)
  ) u_gap (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load_i   (gap_load_c),
    .en_i     (state_q == GAP),
    .expire_o (gap_expire)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    done_status_d = done_status_q;
    gap_load_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d.src = req_src;
          req_d.dst = req_dst;
          req_d.len = req_len;
          if (req_len == '0) begin
            done_status_d = '0;
            state_d       = DONE;
          end else begin
            state_d = WR_SRC;
          end
        end
      end
      WR_SRC: if (wr_ack_c) state_d = WR_DST;
      WR_DST: if (wr_ack_c) state_d = WR_LEN;
      WR_LEN: if (wr_ack_c) state_d = WR_CTL;
      WR_CTL: begin
        if (wr_ack_c) begin
          state_d    = GAP;
          gap_load_c = 1'b1;
        end
      end
      GAP: if (gap_expire) state_d = RD;
      RD:  if (csr_read_q && !csr_waitrequest) state_d = RSP;
      RSP: begin
        if (csr_readdatavalid) begin
          if (csr_readdata[BUSY_BIT]) begin
            state_d    = GAP;
            gap_load_c = 1'b1;
          end else begin
            done_status_d = csr_readdata[STAT_W-1:0];
            state_d       = DONE;
          end
        end
      end
      DONE:    if (done_valid_q && done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are decoded from the next state so they register alongside it.
    req_ready_d     = (state_d == IDLE);
    done_valid_d    = (state_d == DONE);
    csr_write_d     = 1'b0;
    csr_read_d      = 1'b0;
    csr_address_d   = '0;
    csr_writedata_d = '0;
    unique case (state_d)
      WR_SRC: begin
        csr_write_d     = 1'b1;
        csr_address_d   = DESC_BASE + CSR_AW'(OFF_SRC);
        csr_writedata_d = CSR_DW'(req_d.src);
      end
      WR_DST: begin
        csr_write_d     = 1'b1;
        csr_address_d   = DESC_BASE + CSR_AW'(OFF_DST);
        csr_writedata_d = CSR_DW'(req_d.dst);
      end
      WR_LEN: begin
        csr_write_d     = 1'b1;
        csr_address_d   = DESC_BASE + CSR_AW'(OFF_LEN);
        csr_writedata_d = CSR_DW'(req_d.len);
      end
      WR_CTL: begin
        csr_write_d     = 1'b1;
        csr_address_d   = DESC_BASE + CSR_AW'(OFF_CTL);
        csr_writedata_d = CTL_WORD;
      end
      RD: begin
        csr_read_d    = 1'b1;
        csr_address_d = STATUS_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q         <= IDLE;
      req_q           <= '0;
      req_ready_q     <= 1'b0;
      done_valid_q    <= 1'b0;
      done_status_q   <= '0;
      csr_address_q   <= '0;
      csr_writedata_q <= '0;
      csr_write_q     <= 1'b0;
      csr_read_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      req_ready_q     <= req_ready_d;
      done_valid_q    <= done_valid_d;
      done_status_q   <= done_status_d;
      csr_address_q   <= csr_address_d;
      csr_writedata_q <= csr_writedata_d;
      csr_write_q     <= csr_write_d;
      csr_read_q      <= csr_read_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign done_valid     = done_valid_q;
  assign done_status    = done_status_q;
  assign csr_address    = csr_address_q;
  assign csr_writedata  = csr_writedata_q;
  assign csr_write      = csr_write_q;
  assign csr_read       = csr_read_q;
  assign csr_byteenable = 8'hFF;
  assign csr_burstcount = 1'b1;

endmodule

// File: tb/tb_msgdma_desc_submit.sv
// Bench for msgdma_desc_submit: a behavioural CSR slave plus a per-transfer
// model of the expected descriptor writes, poll count and final status.
module tb_msgdma_desc_submit;

  localparam logic [7:0] BASE = 8'h20;
  localparam logic [7:0] STAT = 8'h00;
  localparam int         GAPN = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [47:0] req_src = '0;
  logic [47:0] req_dst = '0;
  logic [31:0] req_len = '0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [31:0] done_status;
  logic [7:0]  csr_address;
  logic [63:0] csr_writedata;
  logic [7:0]  csr_byteenable;
  logic        csr_write;
  logic        csr_read;
  logic        csr_burstcount;
  logic [63:0] csr_readdata = '0;
  logic        csr_readdatavalid = 1'b0;
  logic        csr_waitrequest = 1'b0;

  msgdma_desc_submit #(
    .DESC_BASE   (BASE),
    .STATUS_ADDR (STAT),
    .POLL_GAP    (GAPN)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_src           (req_src),
    .req_dst           (req_dst),
    .req_len           (req_len),
    .done_valid        (done_valid),
    .done_ready        (done_ready),
    .done_status       (done_status),
    .csr_address       (csr_address),
    .csr_writedata     (csr_writedata),
    .csr_byteenable    (csr_byteenable),
    .csr_write         (csr_write),
    .csr_read          (csr_read),
    .csr_burstcount    (csr_burstcount),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .csr_waitrequest   (csr_waitrequest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CSR slave state and transaction log
  int          wait_mode = 0;   // 0 none, 1 random, 2 stall dst write 3 cycles
  int          stall_cnt = 0;
  int          resp_lat  = 1;
  bit          spur_en   = 0;
  logic [63:0] stat_q[$];
  logic [7:0]  wa_log[$];
  logic [63:0] wd_log[$];
  int          wt_log[$];
  int          rd_count = 0;
  int          dst_seen = 0;
  int          last_evt = 0;
  bit          pending  = 0;
  int          lat      = 0;
  bit          pw_stall = 0;
  bit          pr_stall = 0;
  bit          prev_rd  = 0;
  logic [7:0]  p_addr   = '0;
  logic [63:0] p_data   = '0;

  always @(negedge clk) begin : slave
    bit w;
    if (!rst_n) begin
      pending = 0; csr_readdatavalid = 1'b0; csr_waitrequest = 1'b0;
      pw_stall = 0; pr_stall = 0; prev_rd = 0;
    end else begin
      chk("csr_const", {csr_byteenable, csr_burstcount}, {8'hFF, 1'b1});
      chk("rw_overlap", csr_read & csr_write, 1'b0);
      if (pw_stall) chk("wr_hold", {csr_write, csr_address, csr_writedata}, {1'b1, p_addr, p_data});
      if (pr_stall) chk("rd_hold", {csr_read, csr_address}, {1'b1, STAT});
      if (csr_read && !prev_rd) begin
        chk("poll_gap", cyc - last_evt, GAPN + 1);
        chk("rd_addr", csr_address, STAT);
      end
      if (csr_write && csr_address == BASE + 8'd1) dst_seen++;
      csr_readdatavalid = 1'b0;
      if (pending) begin
        if (lat <= 1) begin
          csr_readdatavalid = 1'b1;
          csr_readdata = (stat_q.size() > 0) ? stat_q.pop_front() : 64'h1;
          pending = 0;
          last_evt = cyc;
        end else lat--;
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        csr_readdatavalid = 1'b1;
        csr_readdata = {$urandom, $urandom};
      end
      case (wait_mode)
        0:       w = 1'b0;
        1:       w = ($urandom_range(0, 2) == 0);
        default: w = csr_write && (csr_address == BASE + 8'd1) && (stall_cnt < 3);
      endcase
      if (wait_mode == 2 && w) stall_cnt++;
      csr_waitrequest = w;
      if (csr_write && !w) begin
        wa_log.push_back(csr_address);
        wd_log.push_back(csr_writedata);
        wt_log.push_back(cyc);
        if (csr_address == BASE + 8'd3) last_evt = cyc;
      end
      if (csr_read && !w) begin
        rd_count++;
        pending = 1;
        lat = resp_lat;
      end
      pw_stall = csr_write && w;
      pr_stall = csr_read && w;
      p_addr   = csr_address;
      p_data   = csr_writedata;
      prev_rd  = csr_read;
    end
  end

  task automatic clear_log();
    wa_log.delete(); wd_log.delete(); wt_log.delete(); stat_q.delete();
    rd_count = 0; dst_seen = 0; stall_cnt = 0;
  endtask

  task automatic send_req(input logic [47:0] src, input logic [47:0] dst, input logic [31:0] len);
    int n = 0;
    req_src = src; req_dst = dst; req_len = len; req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // One complete transfer: model expectations, drive it, then check results.
  task automatic run_req(input logic [47:0] src, input logic [47:0] dst, input logic [31:0] len,
                         input int nbusy, input logic [31:0] fin, input int hold);
    logic [63:0] ed[4];
    logic [31:0] exp_st;
    int exp_w, exp_r, n;
    logic [31:0] b;
    clear_log();
    ed[0] = {16'h0, src};
    ed[1] = {16'h0, dst};
    ed[2] = {32'h0, len};
    ed[3] = 64'h0000_0000_8000_0000;
    exp_w  = (len == 0) ? 0 : 4;
    exp_r  = (len == 0) ? 0 : nbusy + 1;
    exp_st = (len == 0) ? 32'h0 : fin;
    if (len != 0) begin
      for (int i = 0; i < nbusy; i++) begin
        b = $urandom; b[0] = 1'b1;
        stat_q.push_back({$urandom, b});
      end
      stat_q.push_back({$urandom, fin});
    end
    send_req(src, dst, len);
    if (len == 0) chk("zlen_next", {done_valid, done_status}, {1'b1, 32'h0});
    n = 0;
    while (!done_valid && n < 4000) begin @(negedge clk); n++; end
    chk("done_seen", done_valid, 1'b1);
    chk("done_status", done_status, exp_st);
    chk("wr_count", wa_log.size(), exp_w);
    chk("rd_count", rd_count, exp_r);
    for (int i = 0; i < exp_w && i < wa_log.size(); i++) begin
      chk("wr_addr", wa_log[i], BASE + 8'(i));
      chk("wr_data", wd_log[i], ed[i]);
    end
    if (wait_mode == 0 && wt_log.size() == 4)
      for (int i = 1; i < 4; i++) chk("wr_consec", wt_log[i] - wt_log[i-1], 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold", {done_valid, req_ready, done_status}, {1'b1, 1'b0, exp_st});
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    chk("done_release", {done_valid, req_ready}, {1'b0, 1'b1});
  endtask

  initial begin : main
    logic [47:0] s, d;
    logic [31:0] l, f;
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_outs", {req_ready, done_valid, done_status, csr_write, csr_read, csr_address, csr_writedata}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst0", req_ready, 1'b0);
    @(posedge clk);
    #1 chk("ready_after_rst1", req_ready, 1'b1);
    @(negedge clk);

    // basic, no stalls
    wait_mode = 0; resp_lat = 2;
    run_req(48'h1000, 48'h2000, 32'd256, 0, 32'h0, 0);

    // waitrequest on the dst word
    wait_mode = 2;
    run_req(48'h0000_DEAD_0000, 48'h1234_5678_9ABC, 32'h40, 0, 32'h10, 0);
    chk("stall_dst_cycles", dst_seen, 4);

    // busy twice then idle, with done backpressure
    wait_mode = 0;
    run_req(48'h3000, 48'h4000, 32'd64, 2, 32'h0000_0002, 10);

    // zero length
    run_req(48'h5000, 48'h6000, 32'd0, 0, 32'h0, 2);

    // reset while waiting for read data
    clear_log();
    resp_lat = 20;
    stat_q.push_back(64'h0);
    send_req(48'h7000, 48'h8000, 32'd8);
    n = 0;
    while (rd_count == 0 && n < 200) begin @(negedge clk); n++; end
    chk("rst_rd_seen", rd_count, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_rsp_outs", {req_ready, done_valid, done_status, csr_write, csr_read, csr_address, csr_writedata}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rsp_ready0", req_ready, 1'b0);
    @(posedge clk);
    #1 chk("rst_rsp_ready1", req_ready, 1'b1);
    @(negedge clk);
    resp_lat = 1;
    run_req(48'h9000, 48'hA000, 32'd128, 1, 32'h0000_0A00, 1);

    // randomized transfers with random stalls and stray readdatavalid
    wait_mode = 1; spur_en = 1;
    for (int t = 0; t < 8; t++) begin
      s = 48'({$urandom, $urandom});
      d = 48'({$urandom, $urandom});
      l = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      f = $urandom; f[0] = 1'b0;
      resp_lat = $urandom_range(1, 4);
      run_req(s, d, l, $urandom_range(0, 3), f, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
